// File: rtl/upload_frame_filter.sv
// ---------------------------------------------------------------------------
// upload_frame_filter
//
// Store-and-forward validator sitting between the upload arbiter and the USB
// upload processor. Incoming frames have the layout
//     HDR_H | HDR_L | src | lenH | lenL | payload[len] | csum
// where csum is the XOR of src, lenH, lenL and every payload byte. A whole
// frame is buffered and only replayed downstream once its checksum matches.
// Frames with a bad checksum, an oversize length, or whose request drops
// mid-frame are discarded and counted.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   in_req          upstream request, high for the whole frame
//   in_data         incoming frame byte
//   in_source       sideband source tag (informational only)
//   in_valid        incoming byte valid
//   in_ready        byte accepted when in_valid & in_ready
//   out_valid       outgoing byte valid
//   out_data        outgoing byte (full frame incl. header and checksum)
//   out_last        high with the checksum byte
//   out_ready       downstream ready
//   frame_ok_cnt    frames forwarded (saturating)
//   frame_err_cnt   frames dropped (saturating)
//   err_pulse       one-cycle pulse per dropped frame
// ---------------------------------------------------------------------------
module upload_frame_filter #(
    parameter logic [7:0] HDR_H       = 8'hAA,
    parameter logic [7:0] HDR_L       = 8'h44,
    parameter int         MAX_PAYLOAD = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_req,
    input  logic [7:0]  in_data,
    input  logic [7:0]  in_source,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic [15:0] frame_ok_cnt,
    output logic [15:0] frame_err_cnt,
    output logic        err_pulse
);

    localparam int          BUF_DEPTH = MAX_PAYLOAD + 6;
    localparam int          IDX_W     = $clog2(BUF_DEPTH);
    localparam logic [15:0] MAX_LEN   = 16'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        ST_HDR_H,
        ST_HDR_L,
        ST_SRC,
        ST_LEN_H,
        ST_LEN_L,
        ST_DATA,
        ST_CSUM,
        ST_SEND
    } state_t;

    state_t             state_reg, state_next;
    logic               in_ready_reg;
    logic [IDX_W-1:0]   wr_idx_reg, wr_idx_next;
    logic [IDX_W-1:0]   rd_idx_reg;
    logic [IDX_W-1:0]   last_idx_reg;
    logic [IDX_W-1:0]   remain_reg;
    logic [7:0]         len_h_reg;
    logic [7:0]         csum_reg;
    logic               out_valid_reg;
    logic [7:0]         out_data_reg;
    logic               out_last_reg;
    logic [15:0]        ok_cnt_reg;
    logic [15:0]        err_cnt_reg;
    logic               err_pulse_reg;

    logic [7:0]         buf_mem [0:BUF_DEPTH-1];

    logic               accept;
    logic               take;
    logic               in_frame;
    logic               abort;
    logic [15:0]        len_full;
    logic               send_done;
    logic               rd_en;
    logic               frame_err;

    // The source tag is carried for upstream bookkeeping only.
    logic               unused_source;
    assign unused_source = ^in_source;

    assign accept    = in_valid && in_ready_reg;
    assign in_frame  = (state_reg == ST_SRC)   || (state_reg == ST_LEN_H) ||
                       (state_reg == ST_LEN_L) || (state_reg == ST_DATA)  ||
                       (state_reg == ST_CSUM);
    // A dropped request wins over a byte offered in the same cycle.
    assign abort     = in_frame && !in_req;
    assign take      = accept && !abort;
    assign len_full  = {len_h_reg, in_data};
    assign send_done = (state_reg == ST_SEND) && out_valid_reg && out_ready && out_last_reg;
    // Fetch the next buffered byte when the output register is empty or is
    // being consumed this cycle (and the frame is not already finished).
    assign rd_en     = (state_reg == ST_SEND) &&
                       (!out_valid_reg || (out_ready && !out_last_reg));

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_HDR_H;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        frame_err  = 1'b0;
        if (abort) begin
            state_next = ST_HDR_H;
            frame_err  = 1'b1;
        end else begin
            case (state_reg)
                ST_HDR_H: begin
                    if (accept && in_data == HDR_H) state_next = ST_HDR_L;
                end
                ST_HDR_L: begin
                    if (accept) begin
                        if (in_data == HDR_L)      state_next = ST_SRC;
                        else if (in_data == HDR_H) state_next = ST_HDR_L;
                        else                       state_next = ST_HDR_H;
                    end
                end
                ST_SRC: begin
                    if (accept) state_next = ST_LEN_H;
                end
                ST_LEN_H: begin
                    if (accept) state_next = ST_LEN_L;
                end
                ST_LEN_L: begin
                    if (accept) begin
                        if (len_full > MAX_LEN) begin
                            state_next = ST_HDR_H;
                            frame_err  = 1'b1;
                        end else if (len_full == 16'd0) begin
                            state_next = ST_CSUM;
                        end else begin
                            state_next = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept && remain_reg == IDX_W'(1)) state_next = ST_CSUM;
                end
                ST_CSUM: begin
                    if (accept) begin
                        if (in_data == csum_reg) begin
                            state_next = ST_SEND;
                        end else begin
                            state_next = ST_HDR_H;
                            frame_err  = 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (send_done) state_next = ST_HDR_H;
                end
                default: state_next = ST_HDR_H;
            endcase
        end
    end

    // Write pointer follows the state the byte leads into: a repeated HDR_H
    // while hunting for HDR_L rewinds to slot 1 so the header stays aligned.
    always_comb begin
        wr_idx_next = wr_idx_reg;
        if (accept || abort) begin
            case (state_next)
                ST_HDR_H, ST_SEND: wr_idx_next = '0;
                ST_HDR_L:          wr_idx_next = IDX_W'(1);
                default:           wr_idx_next = wr_idx_reg + IDX_W'(1);
            endcase
        end
    end

    // ---------------- frame buffer write port ----------------
    always_ff @(posedge clk) begin
        if (accept && state_reg != ST_SEND) begin
            buf_mem[wr_idx_reg] <= in_data;
        end
    end

    // ---------------- receive datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_reg <= 1'b0;
            wr_idx_reg   <= '0;
            last_idx_reg <= '0;
            remain_reg   <= '0;
            len_h_reg    <= 8'd0;
            csum_reg     <= 8'd0;
        end else begin
            in_ready_reg <= (state_next != ST_SEND);
            wr_idx_reg   <= wr_idx_next;
            if (take) begin
                case (state_reg)
                    ST_SRC: csum_reg <= in_data;
                    ST_LEN_H: begin
                        len_h_reg <= in_data;
                        csum_reg  <= csum_reg ^ in_data;
                    end
                    ST_LEN_L: begin
                        // Only meaningful when the length is in range; an
                        // oversize frame is dropped before these are used.
                        remain_reg   <= len_full[IDX_W-1:0];
                        last_idx_reg <= len_full[IDX_W-1:0] + IDX_W'(5);
                        csum_reg     <= csum_reg ^ in_data;
                    end
                    ST_DATA: begin
                        remain_reg <= remain_reg - IDX_W'(1);
                        csum_reg   <= csum_reg ^ in_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- transmit datapath (registered buffer read) ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= 8'd0;
            out_last_reg  <= 1'b0;
        end else if (state_reg == ST_SEND) begin
            if (rd_en) begin
                out_data_reg  <= buf_mem[rd_idx_reg];
                out_valid_reg <= 1'b1;
                out_last_reg  <= (rd_idx_reg == last_idx_reg);
                rd_idx_reg    <= rd_idx_reg + IDX_W'(1);
            end else if (send_done) begin
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end
        end else begin
            rd_idx_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end
    end

    // ---------------- statistics ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ok_cnt_reg    <= 16'd0;
            err_cnt_reg   <= 16'd0;
            err_pulse_reg <= 1'b0;
        end else begin
            err_pulse_reg <= frame_err;
            if (send_done && ok_cnt_reg != 16'hFFFF) begin
                ok_cnt_reg <= ok_cnt_reg + 16'd1;
            end
            if (frame_err && err_cnt_reg != 16'hFFFF) begin
                err_cnt_reg <= err_cnt_reg + 16'd1;
            end
        end
    end

    assign in_ready      = in_ready_reg;
    assign out_valid     = out_valid_reg;
    assign out_data      = out_data_reg;
    assign out_last      = out_last_reg;
    assign frame_ok_cnt  = ok_cnt_reg;
    assign frame_err_cnt = err_cnt_reg;
    assign err_pulse     = err_pulse_reg;

endmodule

// File: tb/tb_upload_frame_filter.sv
// ---------------------------------------------------------------------------
// tb_upload_frame_filter
//
// Directed bench for upload_frame_filter. Stimulus changes 1 time unit after
// the rising edge; outputs are sampled on the falling edge. Each frame prints
// one line; every comparison goes through chk().
// ---------------------------------------------------------------------------
module tb_upload_frame_filter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_req = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic [7:0]  in_source = 8'd3;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic [15:0] frame_ok_cnt;
    logic [15:0] frame_err_cnt;
    logic        err_pulse;

    always #5 clk = ~clk;

    upload_frame_filter dut (
        .clk           (clk),
        .rst           (rst),
        .in_req        (in_req),
        .in_data       (in_data),
        .in_source     (in_source),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_ready     (out_ready),
        .frame_ok_cnt  (frame_ok_cnt),
        .frame_err_cnt (frame_err_cnt),
        .err_pulse     (err_pulse)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic       rx_last_q[$];
    int         pulse_cnt = 0;
    logic       toggle_rdy = 1'b0;

    // Output monitor: collect handshaken bytes, count error pulses and check
    // that a stalled byte is held until it is taken.
    initial begin
        logic       stall_prev;
        logic [7:0] stall_data;
        logic       stall_last;
        stall_prev = 1'b0;
        stall_data = 8'd0;
        stall_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev && out_valid)
                    chk("stall_hold", 32'({out_last, out_data}), 32'({stall_last, stall_data}));
                if (out_valid && out_ready) begin
                    rx_q.push_back(out_data);
                    rx_last_q.push_back(out_last);
                end
                if (err_pulse) pulse_cnt++;
                stall_prev = out_valid && !out_ready;
                stall_data = out_data;
                stall_last = out_last;
            end
        end
    end

    // Downstream back-pressure generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_rdy) out_ready = ~out_ready;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard    = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            tick(1);
            guard++;
        end
        if (guard >= 200) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic send_q();
        foreach (tx_q[i]) send_byte(tx_q[i]);
    endtask

    task automatic check_rx(input string tag);
        int guard;
        int n;
        guard = 0;
        n     = exp_q.size();
        while (rx_q.size() < n && guard < 400) begin
            tick(1);
            guard++;
        end
        chk({tag, "_count"}, 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < n && i < rx_q.size(); i++) begin
            chk({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
            chk({tag, "_last"}, 32'(rx_last_q[i]), 32'(i == n - 1));
        end
        $display("frame %s: %0d bytes out, ok_cnt=%0d err_cnt=%0d", tag, rx_q.size(),
                 frame_ok_cnt, frame_err_cnt);
        rx_q.delete();
        rx_last_q.delete();
    endtask

    task automatic load_good();
        // cs = 0A^00^05^01^10^20^30^40 = 4E
        tx_q  = '{8'hAA, 8'h44, 8'h0A, 8'h00, 8'h05, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 8'h4E};
        exp_q = tx_q;
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick(3);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_ok_cnt", 32'(frame_ok_cnt), 32'd0);
        chk("rst_err_cnt", 32'(frame_err_cnt), 32'd0);
        chk("rst_err_pulse", 32'(err_pulse), 32'd0);
        rst = 1'b0;
        chk("post_rst_in_ready_low", 32'(in_ready), 32'd0);
        tick(1);
        chk("post_rst_in_ready_high", 32'(in_ready), 32'd1);

        // ---------------- 1: good frame, latency ----------------
        load_good();
        send_q();
        chk("lat_not_yet", 32'(out_valid), 32'd0);
        chk("send_in_ready", 32'(in_ready), 32'd0);
        tick(1);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_byte0", 32'(out_data), 32'hAA);
        check_rx("good1");
        chk("t1_ok_cnt", 32'(frame_ok_cnt), 32'd1);
        chk("t1_err_cnt", 32'(frame_err_cnt), 32'd0);

        // ---------------- 2: bad checksum, then good ----------------
        tx_q = '{8'hAA, 8'h44, 8'h0A, 8'h00, 8'h05, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 8'hB1};
        send_q();
        tick(20);
        chk("t2_no_out", 32'(rx_q.size()), 32'd0);
        chk("t2_err_cnt", 32'(frame_err_cnt), 32'd1);
        chk("t2_pulse_cnt", 32'(pulse_cnt), 32'd1);
        chk("t2_ok_cnt", 32'(frame_ok_cnt), 32'd1);
        $display("frame badcsum: dropped, err_cnt=%0d", frame_err_cnt);
        load_good();
        send_q();
        check_rx("good2");
        chk("t2b_ok_cnt", 32'(frame_ok_cnt), 32'd2);

        // ---------------- 3: junk prefix, zero-length frame ----------------
        tx_q  = '{8'h55, 8'hAA, 8'hAA, 8'h44, 8'h0B, 8'h00, 8'h00, 8'h0B};
        exp_q = '{8'hAA, 8'h44, 8'h0B, 8'h00, 8'h00, 8'h0B};
        send_q();
        check_rx("junk_len0");
        chk("t3_ok_cnt", 32'(frame_ok_cnt), 32'd3);
        chk("t3_err_cnt", 32'(frame_err_cnt), 32'd1);

        // ---------------- 4: oversize length ----------------
        tx_q = '{8'hAA, 8'h44, 8'h0C, 8'h00, 8'h41};
        send_q();
        tick(2);
        chk("t4_err_cnt", 32'(frame_err_cnt), 32'd2);
        chk("t4_pulse_cnt", 32'(pulse_cnt), 32'd2);
        chk("t4_in_ready", 32'(in_ready), 32'd1);
        $display("frame oversize: dropped, err_cnt=%0d", frame_err_cnt);
        load_good();
        send_q();
        check_rx("after_oversize");
        chk("t4_ok_cnt", 32'(frame_ok_cnt), 32'd4);

        // ---------------- 5: output back-pressure ----------------
        load_good();
        send_q();
        toggle_rdy = 1'b1;
        chk("t5_send_in_ready", 32'(in_ready), 32'd0);
        tick(3);
        chk("t5_send_in_ready2", 32'(in_ready), 32'd0);
        check_rx("stalled");
        toggle_rdy = 1'b0;
        out_ready  = 1'b1;
        chk("t5_ok_cnt", 32'(frame_ok_cnt), 32'd5);

        // ---------------- 6: abort, then reset mid-SEND ----------------
        tx_q = '{8'hAA, 8'h44, 8'h0A, 8'h00, 8'h05, 8'h01, 8'h10, 8'h20};
        send_q();
        in_req = 1'b0;
        tick(2);
        chk("t6_err_cnt", 32'(frame_err_cnt), 32'd3);
        chk("t6_pulse_cnt", 32'(pulse_cnt), 32'd3);
        $display("frame aborted: dropped, err_cnt=%0d", frame_err_cnt);
        in_req = 1'b1;
        load_good();
        send_q();
        check_rx("after_abort");
        chk("t6_ok_cnt", 32'(frame_ok_cnt), 32'd6);

        load_good();
        send_q();
        begin
            int guard;
            guard = 0;
            while (rx_q.size() < 2 && guard < 100) begin
                tick(1);
                guard++;
            end
            chk("t6_send_started", 32'(rx_q.size() >= 2), 32'd1);
        end
        rst = 1'b1;
        tick(1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_out_last", 32'(out_last), 32'd0);
        chk("midrst_ok_cnt", 32'(frame_ok_cnt), 32'd0);
        chk("midrst_err_cnt", 32'(frame_err_cnt), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        $display("reset mid-send: %0d bytes seen before reset", rx_q.size());
        rx_q.delete();
        rx_last_q.delete();
        rst = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
